// File: rtl/param_ring_buffer.sv
// Circular sample buffer with valid/ready on both sides, occupancy status and sample/drop statistics.
// OVERWRITE selects back-pressure when full (0) or replacing the oldest entry (1).
module param_ring_buffer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int OVERWRITE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level_q;
    logic [CNT_W-1:0]  sample_q;
    logic [CNT_W-1:0]  drop_q;
    logic              push;
    logic              pop;
    logic              drop;

    assign empty       = (level_q == '0);
    assign full        = (level_q == LEVEL_MAX);
    assign almost_full = (level_q >= AFULL_LVL);
    assign level       = level_q;
    assign sample_cnt  = sample_q;
    assign drop_cnt    = drop_q;

    // Handshake readiness depends only on registered level and clear, never on the opposite side.
    assign in_ready  = !clear && (!full || (OVERWRITE != 0));
    assign out_valid = !empty && !clear;
    assign out_data  = mem[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    // A push into a full ring with no concurrent pop replaces the head entry.
    assign drop = push && !pop && full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            sample_q <= '0;
            drop_q   <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                sample_q <= sample_q + 1'b1;
            end
            if (pop || drop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop && !full) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

endmodule
